// File: rtl/seq_div_16by8.sv
// seq_div_16by8
// Iterative restoring divider. It takes a 2*DW-bit unsigned dividend and a
// DW-bit unsigned divisor, and produces one quotient bit per clock.
// It returns a 2*DW-bit quotient and a DW-bit remainder.
// A zero divisor is reported through div_zero, with an all-ones quotient.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     operand pair valid
//   in_ready   out  1     divider idle, can accept an operand pair
//   dividend   in   2*DW  numerator, unsigned
//   divisor    in   DW    denominator, unsigned
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts the result
//   quotient   out  2*DW  unsigned quotient
//   remainder  out  DW    unsigned remainder
//   div_zero   out  1     divisor of this result was zero
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// CALC  | shifting out one quotient bit per cycle, 2*DW cycles
// DONE  | result presented, out_valid=1, held until out_ready

module seq_div_16by8 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_zero
);

  localparam int          CW   = $clog2(2*DW);
  localparam logic [CW-1:0] LAST = CW'(2*DW-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // work holds the unconsumed dividend bits at the top.
  // Quotient bits fill in from the bottom as the dividend bits shift out.
  logic [2*DW-1:0] work;
  logic [DW-1:0]   divisor_q;
  logic [DW-1:0]   partial;
  logic [DW-1:0]   partial_n;
  logic [CW-1:0]   cnt;
  logic [DW:0]     trial;
  logic            q_bit;
  logic            accept;

  assign accept = in_valid && in_ready;

  // The trial remainder needs DW+1 bits: the shifted-in value can reach 2*divisor-1.
  // After a subtraction the result is always below divisor, so it fits back into DW bits.
  assign trial     = {partial, work[2*DW-1]};
  assign q_bit     = (trial >= {1'b0, divisor_q});
  assign partial_n = q_bit ? (trial[DW-1:0] - divisor_q) : trial[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_n = (divisor != '0) ? CALC : DONE;
      end
      CALC: begin
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      divisor_q <= '0;
      partial   <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (state == IDLE && accept) begin
      if (divisor != '0) begin
        work      <= dividend;
        divisor_q <= divisor;
        partial   <= '0;
        cnt       <= '0;
        div_zero  <= 1'b0;
      end else begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end
    end else if (state == CALC) begin
      work    <= {work[2*DW-2:0], q_bit};
      partial <= partial_n;
      cnt     <= cnt + CW'(1);
      // The output registers change only when the result is complete.
      // They keep their value for the whole time the result is presented.
      if (cnt == LAST) begin
        quotient  <= {work[2*DW-2:0], q_bit};
        remainder <= partial_n;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Testbench for seq_div_16by8 (DW=8).
// Results are checked against plain integer division and modulo.

module tb_seq_div_16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int TIMEOUT = 40;

  seq_div_16by8 #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: unsigned division, with the divide-by-zero result defined.
  function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dz);
    if (b == 0) begin
      q = 16'hFFFF; r = 8'h00; dz = 1'b1;
    end else begin
      q = 16'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
      dz = 1'b0;
    end
  endfunction

  // Performs one transaction.
  // lat is the number of clock edges after the accept edge until out_valid is seen.
  // lat is TIMEOUT if out_valid never rises.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic dz, output int lat);
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder; dz = div_zero;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready/out_valid got %b want 10", {in_ready, out_valid});
    end
    n_tests++;
    if ({quotient, remainder, div_zero} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_out: q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [3] = '{16'h03E8, 16'hFFFF, 16'h1234};
    logic [7:0]  vb [3] = '{8'h07,   8'hFF,   8'h00};
    logic [15:0] q, eq; logic [7:0] r, er; logic dz, edz; int lat, elat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, dz, lat);
      ref_div(va[i], vb[i], eq, er, edz);
      // A zero divisor shows out_valid in the cycle right after accept,
      // which is zero further edges.
      elat = (vb[i] == 0) ? 0 : 16;
      n_tests++;
      if (lat !== elat) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d edges want %0d", i, lat, elat);
      end
      n_tests++;
      if ({q, r, dz} !== {eq, er, edz}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 i, va[i], vb[i], q, r, dz, eq, er, edz);
      end
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_release[%0d]: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat = 0; bit busy_ready = 0; bit unstable = 0;
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'h00C8; divisor = 8'h0A;
    @(posedge clk); #1;
    // These operands arrive while the divider is busy and must be ignored.
    dividend = 16'hFFFF; divisor = 8'h01;
    while (!out_valid && lat < TIMEOUT) begin
      if (in_ready !== 1'b0) busy_ready = 1;
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== 16) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d edges want 16", lat);
    end
    for (int i = 0; i < 5; i++) begin
      if (quotient !== 16'h0014 || remainder !== 8'h00 || div_zero !== 1'b0 ||
          out_valid !== 1'b1) unstable = 1;
      if (in_ready !== 1'b0) busy_ready = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (unstable) begin
      n_fail++;
      $display("FAIL bp_hold: q=%h r=%h ov=%b want q=0014 r=00 ov=1", quotient, remainder, out_valid);
    end
    n_tests++;
    if (busy_ready) begin
      n_fail++;
      $display("FAIL bp_in_ready: in_ready got 1 while busy, want 0");
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] q; logic [7:0] r; logic dz; int lat;
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'h1234; divisor = 8'h05;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_tests++;
    if ({quotient, remainder, div_zero} !== 25'd0) begin
      n_fail++;
      $display("FAIL rst_mid_out: q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    run_op(16'h0064, 8'h03, q, r, dz, lat);
    n_tests++;
    if ({q, r, dz} !== {16'h0021, 8'h01, 1'b0} || lat !== 16) begin
      n_fail++;
      $display("FAIL rst_mid_next: q=%h r=%h dz=%b lat=%0d want q=0021 r=01 dz=0 lat=16",
               q, r, dz, lat);
    end
  endtask

  task automatic test_round_trip();
    logic [15:0] q; logic [7:0] r; logic dz; int lat;
    logic [7:0] a, b;
    for (int i = 0; i < 50; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      run_op(16'(a) * 16'(b), b, q, r, dz, lat);
      n_tests++;
      if (q !== 16'(a) || r !== 8'h00 || dz !== 1'b0 || lat !== 16) begin
        n_fail++;
        $display("FAIL round_trip: %0d*%0d/%0d got q=%0d r=%0d dz=%b lat=%0d", a, b, b, q, r, dz, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] q, eq; logic [7:0] r, er; logic dz, edz; int lat;
    logic [15:0] a; logic [7:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      run_op(a, b, q, r, dz, lat);
      ref_div(a, b, eq, er, edz);
      n_tests++;
      if ({q, r, dz} !== {eq, er, edz} || lat !== ((b == 0) ? 0 : 16)) begin
        n_fail++;
        $display("FAIL random: %h/%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b",
                 a, b, q, r, dz, lat, eq, er, edz);
      end
      if (b != 0) begin
        n_tests++;
        if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b) begin
          n_fail++;
          $display("FAIL invariant: %h/%h got q=%h r=%h", a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
